// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared types and constants for the data-memory responder.
// Revision: 1.0
// ============================================================================
package mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_BEAT0 = 3'd2,
      ST_BEAT1 = 3'd3,
      ST_WACK  = 3'd4
   } state_e;

   localparam int BLOCK_WORDS = 2;
   localparam int LAT_CNT_W   = 4;

endpackage
`default_nettype wire

// File: rtl/sram_sp.sv
`default_nettype none
// ============================================================================
// Module  : sram_sp
// Brief   : Single-port word storage, synchronous write, combinational read.
// Revision: 1.0
// ============================================================================
module sram_sp #(
   parameter int DEPTH      = 1024,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_W     = 10
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : Fixed-latency memory responder: write-through acks, 2-word refills.
// Revision: 1.0
// ============================================================================
module dmem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_data,
   output logic                  resp_last
);

   localparam int                     c_IDX_W     = $clog2(MEM_WORDS);
   localparam logic [c_IDX_W-1:0]     c_BLK_MASK  = c_IDX_W'(BLOCK_WORDS - 1);
   localparam logic [LAT_CNT_W-1:0]   c_WAIT_LOAD = (LATENCY > 1) ? LAT_CNT_W'(LATENCY - 2) : '0;

   state_e                  r_state;
   logic [LAT_CNT_W-1:0]    r_cnt;
   logic                    r_we;
   logic [c_IDX_W-1:0]      r_idx;
   logic                    r_req_ready;
   logic                    r_resp_valid;
   logic                    r_resp_last;
   logic [DATA_WIDTH-1:0]   r_resp_data;

   logic [c_IDX_W-1:0]      w_req_idx;
   logic                    w_accept;
   logic                    w_launch;
   logic                    w_launch_we;
   logic                    w_mem_we;
   logic [c_IDX_W-1:0]      w_mem_addr;
   logic [DATA_WIDTH-1:0]   w_mem_rdata;
   logic                    w_unused_addr;

   // Upper address bits beyond the storage depth alias (wrap) by design.
   assign w_req_idx     = req_addr[2 +: c_IDX_W];
   assign w_unused_addr = ^req_addr;

   assign w_accept    = (r_state == ST_IDLE) && req_valid;
   assign w_launch    = (w_accept && (LATENCY == 1)) ||
                        ((r_state == ST_WAIT) && (r_cnt == '0));
   assign w_launch_we = (r_state == ST_IDLE) ? req_we : r_we;
   assign w_mem_we    = w_accept && req_we;

   // The single port serves the write at acceptance and each refill word
   // on the edge that loads it into the response register.
   always_comb begin
      w_mem_addr = r_idx & ~c_BLK_MASK;
      case (r_state)
         ST_IDLE:  w_mem_addr = req_we ? w_req_idx : (w_req_idx & ~c_BLK_MASK);
         ST_BEAT0: w_mem_addr = r_idx | c_BLK_MASK;
         default:  w_mem_addr = r_idx & ~c_BLK_MASK;
      endcase
   end

   sram_sp #(
      .DEPTH      (MEM_WORDS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_W     (c_IDX_W)
   ) u_sram (
      .clk     (clk),
      .i_we    (w_mem_we),
      .i_addr  (w_mem_addr),
      .i_wdata (req_wdata),
      .o_rdata (w_mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_idx        <= '0;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_last  <= 1'b0;
         r_resp_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_we        <= req_we;
                  r_idx       <= w_req_idx;
                  r_req_ready <= 1'b0;
                  r_cnt       <= c_WAIT_LOAD;
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_BEAT0: begin
               if (resp_ready) begin
                  r_state     <= ST_BEAT1;
                  r_resp_data <= w_mem_rdata;
                  r_resp_last <= 1'b1;
               end
            end
            ST_BEAT1, ST_WACK: begin
               if (resp_ready) begin
                  r_state      <= ST_IDLE;
                  r_req_ready  <= 1'b1;
                  r_resp_valid <= 1'b0;
                  r_resp_last  <= 1'b0;
                  r_resp_data  <= '0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_req_ready <= 1'b1;
            end
         endcase

         // Launch overrides the WAIT/IDLE assignments above (LATENCY=1 skips WAIT).
         if (w_launch) begin
            r_resp_valid <= 1'b1;
            if (w_launch_we) begin
               r_state     <= ST_WACK;
               r_resp_last <= 1'b1;
               r_resp_data <= '0;
            end else begin
               r_state     <= ST_BEAT0;
               r_resp_last <= 1'b0;
               r_resp_data <= w_mem_rdata;
            end
         end
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_last  = r_resp_last;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, storage depth in words (power of 2).
REQ-004 SHALL have parameter LATENCY, default 4, cycles from request acceptance to first response beat (legal range 1..15).
REQ-005 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-006 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have port req_valid  input  1  cache request present.
REQ-009 SHALL have port req_ready  output  1  responder can accept a request.
REQ-010 SHALL have port req_we  input  1  1 = write-through word, 0 = block refill read.
REQ-011 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-012 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-013 SHALL have port resp_valid  output  1  response beat present.
REQ-014 SHALL have port resp_ready  input  1  cache accepts beat.
REQ-015 SHALL have port resp_data  output  DATA_WIDTH  refill word (zero for write acks).
REQ-016 SHALL have port resp_last  output  1  final beat of the response.

Function
REQ-017 SHALL accept a request on the edge where req_valid and req_ready are both high; req_ready SHALL be high only in state IDLE.
REQ-018 SHALL compute word index = req_addr[ADDR_WIDTH-1:2] modulo MEM_WORDS; byte offset is ignored; out-of-range addresses wrap.
REQ-019 SHALL register req_we, req_addr and req_wdata at acceptance; later input changes have no effect.
REQ-020 SHALL implement states IDLE, WAIT, BEAT0, BEAT1, WACK.
REQ-021 SHALL on acceptance go IDLE->WAIT and load a latency counter so that resp_valid first rises exactly LATENCY cycles after the acceptance edge; with LATENCY=1, WAIT lasts zero cycles and the next state is BEAT0 or WACK directly.
REQ-022 SHALL on a write commit req_wdata to the addressed word at the acceptance edge, then WAIT->WACK and issue one beat with resp_last=1 and resp_data=0.
REQ-023 SHALL on a read WAIT->BEAT0->BEAT1 and return a 2-word aligned block: BEAT0 carries word (index & ~1) with resp_last=0; BEAT1 carries word (index | 1) with resp_last=1; the word order does not depend on req_addr[2].
REQ-024 SHALL hold resp_valid, resp_data and resp_last stable while resp_valid=1 and resp_ready=0; a beat advances only on resp_valid and resp_ready both high.
REQ-025 SHALL return BEAT1->IDLE or WACK->IDLE on the final handshake; req_ready SHALL be high in the next cycle, giving at least one idle cycle between transactions.
REQ-026 SHALL ignore req_valid outside IDLE; the requester must hold it until accepted.
REQ-027 SHALL drive resp_valid=0, resp_last=0, resp_data=0 in IDLE and WAIT.

Reset
REQ-028 SHALL on rst force state IDLE, clear the counter and drive req_ready=1 (from the first cycle after reset), resp_valid=0, resp_last=0, resp_data=0.
REQ-029 SHALL, on rst mid-transaction, abandon it with no further beats; a write already committed SHALL remain in memory.
REQ-030 SHALL NOT reset the memory contents.

Structure
REQ-031 SHALL place the state enum, BLOCK_WORDS=2 and the latency counter width in a shared package named mem_pkg.
REQ-032 SHALL implement storage as one sub-module, sram_sp: single-port, synchronous write, combinational read.

Verification
REQ-033 SHALL cover refill read: with LATENCY=4, word 0x40->0xAAAA0000 and word 0x44->0xBBBB0000, read at req_addr=0x44 -> resp_valid rises at cycle +4, beats are 0xAAAA0000 (last=0) then 0xBBBB0000 (last=1).
REQ-034 SHALL cover write-then-read: write 0xDEADBEEF to 0x100, then read 0x100 -> one ack beat with last=1 and data=0, then BEAT0=0xDEADBEEF.
REQ-035 SHALL cover backpressure: hold resp_ready=0 for 3 cycles during BEAT0 -> data stable and no BEAT1 until the handshake.
REQ-036 SHALL cover wrap: with MEM_WORDS=1024, write 0x5 at 0x1000 -> read at 0x0 returns 0x5 in BEAT0.
REQ-037 SHALL cover reset mid-refill: assert rst during WAIT -> no resp_valid afterwards and req_ready=1 in the cycle after rst deasserts.
REQ-038 SHALL cover LATENCY=1: read accepted at cycle N -> BEAT0 valid at cycle N+1.
